// File: rtl/batalla_pkg.sv
// +----------------------------------------------------------------------------+
// | batalla_pkg : shared cell codes, scheduler states and turn constants       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package batalla_pkg;

  typedef enum logic [1:0] {
    WATER = 2'd0,
    SHIP  = 2'd1,
    HIT   = 2'd2,
    MISS  = 2'd3
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_P_WAIT = 3'd1,
    ST_C_WAIT = 3'd2,
    ST_READ   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_OVER   = 3'd6
  } sched_state_t;

  localparam logic TURN_PLAYER = 1'b0;
  localparam logic TURN_PC     = 1'b1;

endpackage

`default_nettype wire

// File: rtl/turn_timer.sv
// +----------------------------------------------------------------------------+
// | turn_timer : per-turn down counter with reload, enable and zero flag       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module turn_timer #(
  parameter int TURN_CYCLES = 15,
  localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic reload,
  input  logic en,
  output logic zero
);

  localparam logic [TW-1:0] c_max = TW'(TURN_CYCLES - 1);

  logic [TW-1:0] r_count;

  // Saturates at zero so a shot accepted on the last cycle leaves 0, not a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= c_max;
    end else if (reload) begin
      r_count <= c_max;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/turn_scheduler.sv
// +----------------------------------------------------------------------------+
// | turn_scheduler : alternates player/PC turns, arbitrates board accesses    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module turn_scheduler
  import batalla_pkg::*;
#(
  parameter int N           = 5,
  parameter int MAX_SHIPS   = 5,
  parameter int TURN_CYCLES = 15,
  localparam int CW = $clog2(N),
  localparam int SW = $clog2(MAX_SHIPS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          player_req,
  input  logic [CW-1:0] player_row,
  input  logic [CW-1:0] player_col,
  input  logic          pc_req,
  input  logic [CW-1:0] pc_row,
  input  logic [CW-1:0] pc_col,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_owner,
  output logic [CW-1:0] mem_row,
  output logic [CW-1:0] mem_col,
  output logic [1:0]    mem_wdata,
  input  logic [1:0]    mem_rdata,
  input  logic          mem_ack,
  output logic          turn,
  output logic          t,
  output logic          disparo,
  output logic          hit,
  output logic          bad_shot,
  output logic [SW-1:0] ships_player,
  output logic [SW-1:0] ships_pc,
  output logic          game_over,
  output logic          winner,
  output logic [2:0]    state_actual
);

  localparam logic [CW:0]   c_n     = (CW + 1)'(N);
  localparam logic [SW-1:0] c_ships = SW'(MAX_SHIPS);

  sched_state_t r_state;
  logic         r_was_ship;

  logic    w_p_valid;
  logic    w_c_valid;
  logic    w_wait;
  logic    w_req_ok;
  logic    w_timer_zero;
  logic    w_timer_reload;
  logic    w_game_end;
  cell_t   w_rcell;
  logic [SW-1:0] w_tgt_ships;

  assign w_p_valid   = player_req && ({1'b0, player_row} < c_n) && ({1'b0, player_col} < c_n);
  assign w_c_valid   = pc_req && ({1'b0, pc_row} < c_n) && ({1'b0, pc_col} < c_n);
  assign w_wait      = (r_state == ST_P_WAIT) || (r_state == ST_C_WAIT);
  assign w_req_ok    = ((r_state == ST_P_WAIT) && w_p_valid) || ((r_state == ST_C_WAIT) && w_c_valid);
  assign w_rcell     = cell_t'(mem_rdata);
  assign w_tgt_ships = mem_owner ? ships_pc : ships_player;
  assign w_game_end  = hit && (w_tgt_ships == '0);

  assign w_timer_reload = (((r_state == ST_IDLE) || (r_state == ST_OVER)) && start)
                        || (w_wait && !w_req_ok && w_timer_zero)
                        || ((r_state == ST_DONE) && !w_game_end);

  turn_timer #(
    .TURN_CYCLES (TURN_CYCLES)
  ) u_turn_timer (
    .clk    (clk),
    .reset  (reset),
    .reload (w_timer_reload),
    .en     (w_wait),
    .zero   (w_timer_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_was_ship   <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_owner    <= 1'b0;
      mem_row      <= '0;
      mem_col      <= '0;
      mem_wdata    <= WATER;
      turn         <= TURN_PLAYER;
      t            <= 1'b0;
      disparo      <= 1'b0;
      hit          <= 1'b0;
      bad_shot     <= 1'b0;
      ships_player <= c_ships;
      ships_pc     <= c_ships;
      game_over    <= 1'b0;
      winner       <= 1'b0;
    end else begin
      t        <= 1'b0;
      disparo  <= 1'b0;
      hit      <= 1'b0;
      bad_shot <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            r_state      <= ST_P_WAIT;
            turn         <= TURN_PLAYER;
            ships_player <= c_ships;
            ships_pc     <= c_ships;
            game_over    <= 1'b0;
            winner       <= 1'b0;
          end
        end
        ST_P_WAIT, ST_C_WAIT: begin
          if (w_req_ok) begin
            r_state   <= ST_READ;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_owner <= (r_state == ST_P_WAIT);
            mem_row   <= (r_state == ST_P_WAIT) ? player_row : pc_row;
            mem_col   <= (r_state == ST_P_WAIT) ? player_col : pc_col;
          end else if (w_timer_zero) begin
            t       <= 1'b1;
            turn    <= ~turn;
            r_state <= (r_state == ST_P_WAIT) ? ST_C_WAIT : ST_P_WAIT;
          end
        end
        ST_READ: begin
          if (mem_ack) begin
            if ((w_rcell == WATER) || (w_rcell == SHIP)) begin
              r_state    <= ST_WRITE;
              mem_we     <= 1'b1;
              mem_wdata  <= (w_rcell == SHIP) ? HIT : MISS;
              r_was_ship <= (w_rcell == SHIP);
            end else begin
              bad_shot <= 1'b1;
              mem_req  <= 1'b0;
              r_state  <= (turn == TURN_PC) ? ST_C_WAIT : ST_P_WAIT;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            r_state <= ST_DONE;
            disparo <= 1'b1;
            hit     <= r_was_ship;
            // Decrement here so the new count is visible alongside disparo.
            if (r_was_ship) begin
              if (mem_owner) begin
                if (ships_pc != '0) ships_pc <= ships_pc - 1'b1;
              end else begin
                if (ships_player != '0) ships_player <= ships_player - 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (w_game_end) begin
            r_state   <= ST_OVER;
            game_over <= 1'b1;
            winner    <= turn;
          end else begin
            turn    <= ~turn;
            r_state <= (turn == TURN_PLAYER) ? ST_C_WAIT : ST_P_WAIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign state_actual = r_state;

endmodule

`default_nettype wire

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
- Sequences the battleship game once ship placement is done.
- Alternates turns between player and PC and runs the per-turn timeout that produces the game FSM's t input.
- Arbitrates the single shared board memory between the player's and the PC's shots, doing a read-check-write per shot.
- Drives the disparo pulse and the ships-remaining counters consumed by the game FSM.

Parameters:
- N, 5, board dimension; coordinates are CW = $clog2(N) bits.
- MAX_SHIPS, 5, ships per side at game start; counter width SW = $clog2(MAX_SHIPS+1).
- TURN_CYCLES, 15, clock cycles allowed per turn before timeout (>=2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse: placement finished, game begins (player first).
- player_req  in  1  player shot request.
- player_row, player_col  in  CW  player target on PC board.
- pc_req  in  1  PC shot request.
- pc_row, pc_col  in  CW  PC target on player board.
- mem_req  out  1  board access request; held until mem_ack.
- mem_we  out  1  0 = read, 1 = write.
- mem_owner  out  1  board addressed: 0 = player board, 1 = PC board.
- mem_row, mem_col  out  CW  cell address; stable while mem_req is high.
- mem_wdata  out  2  cell code written.
- mem_rdata  in  2  cell code read; valid when mem_ack is high.
- mem_ack  in  1  one-cycle completion strobe, sampled on clk.
- turn  out  1  0 = player, 1 = PC.
- t  out  1  one-cycle pulse on turn timeout.
- disparo  out  1  one-cycle pulse when a shot completes.
- hit  out  1  valid with disparo: 1 = ship hit.
- bad_shot  out  1  one-cycle pulse: target already fired at.
- ships_player, ships_pc  out  SW  ships remaining.
- game_over  out  1  high while in OVER.
- winner  out  1  valid with game_over: 0 = player, 1 = PC.
- state_actual  out  3  encoded current state, for debug.

Behaviour:
- Reset (async) values: state IDLE, mem_req=0, mem_we=0, every pulse output 0, turn=0, ships_*=MAX_SHIPS, game_over=0, winner=0, timer=TURN_CYCLES-1. A reset mid-access drops mem_req immediately with no write issued.
- Cell codes: 0 WATER, 1 SHIP, 2 HIT, 3 MISS.
- States: IDLE, P_WAIT, C_WAIT, READ, WRITE, DONE, OVER.
- IDLE: on start, go to P_WAIT with turn=0, ships reloaded to MAX_SHIPS and timer reloaded.
- P_WAIT / C_WAIT:
  - Timer decrements every cycle.
  - Only the current side's req is honoured; the other side's req is ignored.
  - Accepted request: latch owner (P_WAIT -> 1, C_WAIT -> 0) and row/col, go to READ.
  - Timer at 0 with no accepted request: pulse t, flip turn, reload timer, enter the other WAIT state.
  - Request and expiry in the same cycle: the request wins and t is not pulsed.
  - Coordinates >= N are ignored as if req were low.
- READ: mem_req=1, mem_we=0. On mem_ack:
  - rdata WATER or SHIP: go to WRITE.
  - rdata HIT or MISS: pulse bad_shot and return to the same WAIT state. The timer is not reloaded; it resumes from its frozen value.
- WRITE: mem_req=1, mem_we=1, mem_wdata = HIT if the read cell was SHIP, else MISS. On mem_ack, go to DONE.
- The timer is frozen in READ, WRITE and DONE.
- DONE (one cycle):
  - disparo=1; hit=1 if the cell was SHIP.
  - On a hit, the target owner's counter is decremented in the same edge that enters DONE, so the new count is visible with disparo. Counters saturate at 0.
  - Next edge: if the decremented counter reached 0, go to OVER with winner = shooter. Otherwise flip turn, reload the timer and enter the other WAIT state.
- Latency with zero-wait memory (ack in the first req cycle): accept at edge k; READ ack at k+1; WRITE ack at k+2; disparo high in the cycle after edge k+2.
- OVER: game_over=1; all requests ignored; start restarts the game as from IDLE.
- state_actual encoding: IDLE 0, P_WAIT 1, C_WAIT 2, READ 3, WRITE 4, DONE 5, OVER 6.

Decomposition:
- Package batalla_pkg: cell_t enum (WATER/SHIP/HIT/MISS), sched_state_t enum, TURN_PLAYER/TURN_PC constants.
- Sub-module turn_timer: reload / enable / zero flag, counting down from TURN_CYCLES-1.

Test Plan (TURN_CYCLES=8, MAX_SHIPS=2, N=5, memory model acks in the first req cycle):
1. Reset asserted during WRITE -> mem_req low that cycle; after release, ships_player=ships_pc=2, state_actual=0, no write seen by the model.
2. start, player_req (2,3) with the PC cell = SHIP -> READ then WRITE of HIT at owner=1 (2,3); disparo & hit 3 cycles after acceptance; ships_pc=1; turn=1; state_actual=2.
3. start, no requests -> t pulses after exactly 8 cycles in P_WAIT; turn=1; pc_req in the same cycle as P_WAIT expiry is ignored.
4. PC fires at a player cell already MISS -> bad_shot pulse, no write; PC stays in C_WAIT and its remaining timer continues without reload.
5. Player hits both PC ships over successive turns -> after the second hit ships_pc=0, game_over=1, winner=0; further player_req produce no mem_req.
6. Timer at 0 and player_req valid in the same cycle -> shot accepted, no t pulse; player_req with row=5 -> ignored, timeout follows.
